// File: rtl/sequence_player_pkg.sv
// Shared types and helpers for the sequence player: state encoding and play-order bit selection.
package seq_pkg;

  localparam int SEQ_W_DEFAULT = 10;
  localparam int SEQ_MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  // Bit k in play order: counts down from the top when msbFirst, up from bit 0 otherwise.
  function automatic logic play_bit(
    input logic [SEQ_MAX_W-1:0] seqVec,
    input int                   seqW,
    input int                   k,
    input bit                   msbFirst
  );
    logic [5:0] pos;
    pos = msbFirst ? 6'(seqW - 1 - k) : 6'(k);
    return seqVec[pos];
  endfunction

endpackage

// File: rtl/sequence_player_tick_divider.sv
// Hold counter for the sequence player; tick marks the last cycle of each bit's hold period.
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tick = (r_count == LAST) && !i_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/sequence_player.sv
// Replays a latched switch sequence as a timed serial bit stream.
// Define SEQUENCE_PLAYER_LOOP_EN to replay continuously, re-latching the sequence at each wrap.
module sequence_player
  import seq_pkg::*;
#(
  parameter int SEQ_W     = SEQ_W_DEFAULT,
  parameter int TICK_DIV  = 4,
  parameter int MSB_FIRST = 1,
  localparam int IW       = $clog2(SEQ_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEQ_W-1:0] i_sequence,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_bit_out,
  output logic             o_bit_valid,
  output logic [IW-1:0]    o_bit_index,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_W - 1);
  localparam bit            MSB      = (MSB_FIRST != 0);

  state_t                 r_state;
  logic [SEQ_W-1:0]       r_shadow;
  logic                   r_first;
  logic                   w_tick;
  logic                   w_clr;
  logic [IW-1:0]          w_nextIdx;
  logic [SEQ_MAX_W-1:0]   w_shadowWide;
`ifdef SEQUENCE_PLAYER_LOOP_EN
  logic [SEQ_MAX_W-1:0]   w_seqWide;
  assign w_seqWide = SEQ_MAX_W'(i_sequence);
`endif

  assign w_shadowWide = SEQ_MAX_W'(r_shadow);
  assign w_nextIdx    = o_bit_index + 1'b1;

  // The hold counter only runs once the first bit is actually on the wire.
  assign w_clr = (r_state != PLAY) || r_first || i_abort;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  // r_first spends one cycle after the start is accepted so the first bit appears one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_first     <= 1'b0;
      o_bit_out   <= 1'b0;
      o_bit_valid <= 1'b0;
      o_bit_index <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_bit_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          o_bit_out   <= 1'b0;
          o_bit_index <= '0;
          o_busy      <= 1'b0;
          if (i_start && !i_abort) begin
            r_shadow <= i_sequence;
            r_first  <= 1'b1;
            r_state  <= PLAY;
          end
        end
        PLAY: begin
          if (i_abort) begin
            r_state     <= IDLE;
            r_first     <= 1'b0;
            o_bit_out   <= 1'b0;
            o_bit_index <= '0;
            o_busy      <= 1'b0;
          end else if (r_first) begin
            r_first     <= 1'b0;
            o_bit_out   <= play_bit(w_shadowWide, SEQ_W, 0, MSB);
            o_bit_valid <= 1'b1;
            o_bit_index <= '0;
            o_busy      <= 1'b1;
          end else if (w_tick) begin
            if (o_bit_index == LAST_IDX) begin
`ifdef SEQUENCE_PLAYER_LOOP_EN
              r_shadow    <= i_sequence;
              o_bit_out   <= play_bit(w_seqWide, SEQ_W, 0, MSB);
              o_bit_valid <= 1'b1;
              o_bit_index <= '0;
              o_done      <= 1'b1;
`else
              r_state     <= DONE;
              o_done      <= 1'b1;
              o_bit_out   <= 1'b0;
              o_bit_index <= '0;
              o_busy      <= 1'b0;
`endif
            end else begin
              o_bit_index <= w_nextIdx;
              o_bit_out   <= play_bit(w_shadowWide, SEQ_W, int'(w_nextIdx), MSB);
              o_bit_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
